// File: rtl/battleship_shot_controller.sv
// Battleship shot controller: cursor, one-cycle fire strobe, repeat-shot
// blocking, shot/hit tallies and win/loss detection for the 5x5 board.
module battleship_shot_controller #(
    parameter int ROWS       = 5,
    parameter int COLS       = 5,
    parameter int SHIP_CELLS = 5,
    parameter int MAX_SHOTS  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       new_game,
    input  logic       hit_in,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic       fire,
    output logic       busy,
    output logic       repeat_shot,
    output logic [6:0] shots,
    output logic [4:0] hits,
    output logic       won,
    output logic       lost
);

    localparam int CELLS = ROWS * COLS;
    localparam int IW    = $clog2(CELLS);

    localparam logic [4:0] RMAX  = 5'(ROWS - 1);
    localparam logic [4:0] CMAX  = 5'(COLS - 1);
    localparam logic [4:0] HWIN  = 5'(SHIP_CELLS);
    localparam logic [6:0] SLAST = 7'(MAX_SHOTS);

    typedef enum logic [2:0] {
        S_AIM,
        S_FIRE,
        S_WAIT,
        S_WON,
        S_LOST
    } state_t;

    state_t           r_state;
    logic [4:0]       r_row;
    logic [4:0]       r_col;
    logic             r_fire;
    logic             r_busy;
    logic             r_repeat;
    logic [6:0]       r_shots;
    logic [4:0]       r_hits;
    logic             r_won;
    logic             r_lost;
    logic [CELLS-1:0] r_map;
    logic [4:0]       r_prev;

    logic [4:0]    w_btn;
    logic [4:0]    w_edge;
    logic [IW-1:0] w_idx;
    logic [4:0]    w_hits_nx;

    // Bit order: up, down, left, right, fire (LSB first).
    assign w_btn     = {btn_fire, btn_right, btn_left, btn_down, btn_up};
    assign w_edge    = w_btn & ~r_prev;
    assign w_idx     = IW'(32'(r_row) * COLS + 32'(r_col));
    assign w_hits_nx = r_hits + {4'b0, hit_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_AIM;
            r_row    <= '0;
            r_col    <= '0;
            r_fire   <= 1'b0;
            r_busy   <= 1'b0;
            r_repeat <= 1'b0;
            r_shots  <= '0;
            r_hits   <= '0;
            r_won    <= 1'b0;
            r_lost   <= 1'b0;
            r_map    <= '0;
            r_prev   <= '1;
        end else if (new_game) begin
            r_state  <= S_AIM;
            r_row    <= '0;
            r_col    <= '0;
            r_fire   <= 1'b0;
            r_busy   <= 1'b0;
            r_repeat <= 1'b0;
            r_shots  <= '0;
            r_hits   <= '0;
            r_won    <= 1'b0;
            r_lost   <= 1'b0;
            r_map    <= '0;
            r_prev   <= '1;
        end else begin
            r_prev   <= w_btn;
            r_repeat <= 1'b0;
            unique case (r_state)
                S_AIM: begin
                    if (w_edge[4]) begin
                        if (r_map[w_idx]) begin
                            r_repeat <= 1'b1;
                        end else begin
                            r_state <= S_FIRE;
                            r_fire  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_edge[0]) begin
                        r_row <= (r_row == '0) ? RMAX : r_row - 5'd1;
                    end else if (w_edge[1]) begin
                        r_row <= (r_row == RMAX) ? '0 : r_row + 5'd1;
                    end else if (w_edge[2]) begin
                        r_col <= (r_col == '0) ? CMAX : r_col - 5'd1;
                    end else if (w_edge[3]) begin
                        r_col <= (r_col == CMAX) ? '0 : r_col + 5'd1;
                    end
                end
                S_FIRE: begin
                    r_fire       <= 1'b0;
                    r_map[w_idx] <= 1'b1;
                    r_shots      <= r_shots + 7'd1;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Win checked first so a hit on the last shot still wins.
                    r_hits <= w_hits_nx;
                    r_busy <= 1'b0;
                    if (w_hits_nx == HWIN) begin
                        r_state <= S_WON;
                        r_won   <= 1'b1;
                    end else if (r_shots == SLAST) begin
                        r_state <= S_LOST;
                        r_lost  <= 1'b1;
                    end else begin
                        r_state <= S_AIM;
                    end
                end
                S_WON, S_LOST: begin
                end
            endcase
        end
    end

    assign row         = r_row;
    assign col         = r_col;
    assign fire        = r_fire;
    assign busy        = r_busy;
    assign repeat_shot = r_repeat;
    assign shots       = r_shots;
    assign hits        = r_hits;
    assign won         = r_won;
    assign lost        = r_lost;

endmodule

// File: doc/battleship_shot_controller.md
# battleship_shot_controller

Player-facing shot controller that sits directly upstream of the 5x5 battleship board. It converts debounced button levels into a cursor position and a single-cycle fire strobe, blocks repeat shots on cells already fired at, and consumes the board's registered hit result. It also keeps shot and hit tallies and declares game won or lost.

## Interface
- ROWS, 5, board rows; cursor row range 0..ROWS-1
- COLS, 5, board columns; cursor col range 0..COLS-1
- SHIP_CELLS, 5, hits required to win (1..31)
- MAX_SHOTS, 15, shots allowed before loss (1..127)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn_up, btn_down, btn_left, btn_right, btn_fire  in  1 each  debounced levels, synchronous to clk
- new_game  in  1  synchronous restart pulse
- hit_in  in  1  board hit flag, registered by board on fire edge
- row  out  5  cursor row, drives board row
- col  out  5  cursor col, drives board col
- fire  out  1  one-cycle shot strobe to board
- busy  out  1  high in FIRE and WAIT
- repeat_shot  out  1  one-cycle pulse: fire pressed on already-shot cell
- shots  out  7  shots issued
- hits  out  5  hits confirmed
- won, lost  out  1 each  terminal flags, level

## Operation
- Rising-edge detect on every btn_*: prev registers reset to 1, so a button held through reset produces no edge until released and re-pressed.
- FSM states are AIM, FIRE, WAIT, WON and LOST. Reset and new_game enter AIM.
- AIM, move edges: one move per cycle, priority up > down > left > right.
  - Up decrements row; row 0 wraps to ROWS-1.
  - Down increments row; ROWS-1 wraps to 0.
  - Left/right act on col the same way with COLS.
- AIM, fire edge: takes precedence over any move edge in the same cycle, and the moves are dropped.
  - If shot_map[row][col] = 1: pulse repeat_shot, stay in AIM, no counter change.
  - Otherwise: go to FIRE.
- FIRE: fire=1 for exactly one cycle. Set shot_map[row][col], increment shots, go to WAIT. Row/col stay frozen until AIM.
- WAIT: sample hit_in at the end of the cycle; if 1, increment hits.
- End of WAIT, next state, evaluated on the post-update counts:
  - hits = SHIP_CELLS -> WON.
  - Else shots = MAX_SHOTS -> LOST.
  - Else AIM.
  - Win has priority when the final allowed shot hits.
- WON/LOST: won or lost held high. All buttons ignored, fire never asserted. Only new_game or rst exits.
- new_game: accepted in any state. Same effect as rst except synchronous.
- Buttons are ignored in FIRE and WAIT, and their edges are not queued.
- Counters never wrap: a shot is impossible once shots = MAX_SHOTS, since the FSM goes terminal first.
- shot_map is ROWS*COLS bits, indexed row*COLS+col.

## Timing
- Reset values:
  - State AIM.
  - row=0, col=0, shots=0, hits=0.
  - fire, busy, repeat_shot, won and lost all 0.
  - shot_map all 0; btn prev regs all 1.
- A button edge is detected in the cycle the level is first seen high. The resulting cursor move appears on row/col in the next cycle (1-cycle latency).
- Shot sequence:
  - Fire edge in cycle N -> fire=1 in cycle N+1 (FIRE).
  - Board registers hit at the end of N+1.
  - Controller samples hit_in at the end of N+2 (WAIT).
  - Cycle N+3: AIM, WON or LOST, with hits/won/lost updated.
- busy=1 in cycles N+1..N+2.
- repeat_shot is asserted in cycle N+1 for a repeat fire edge in cycle N.
- Async rst mid-shot (FIRE or WAIT): fire drops immediately and the in-flight result is discarded. The board is reset by the same rst.

## Test plan
- Reset, then press right 5 times -> col goes 1,2,3,4,0. Press up once -> row=4.
- Press fire at (2,3) with hit_in=1 in WAIT -> fire high exactly 1 cycle, 1 cycle after the edge. busy for 2 cycles. shots=1, hits=1.
- Press fire again at (2,3) -> repeat_shot pulse, no fire, shots remains 1. Same cycle fire+left at a new cell -> shot fires, col unchanged.
- 5 hits in a row on distinct cells -> won=1 after the 5th WAIT. Further button presses produce no fire and no cursor change. new_game -> all counters 0, AIM.
- 15 misses on distinct cells -> lost=1, shots=15. Variant where the 15th shot is the 5th hit -> won=1, lost=0.
- Assert rst during the WAIT cycle -> fire=0 and all outputs at reset values immediately. Button held through reset is not acted on until released and re-pressed.
